// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the I/D cache memory arbiter.
// Default widths match the cache blocks that sit upstream of the arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-request arbiter: req[0] is the I port, req[1] the D port.
// The caller owns the last-grant history; this block only picks a winner.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    input  logic       rr_en,
    output port_e      winner
);

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        winner = PORT_I;
        case (req)
            2'b10:   winner = PORT_D;
            2'b11: begin
                if (rr_en) begin
                    winner = (last == PORT_I) ? PORT_D : PORT_I;
                end else begin
                    winner = PORT_D;
                end
            end
            default: winner = PORT_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave line memory arbiter.
// Commands are registered; mem_ready is steered back only to the granted port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q;
    port_e             grant_q;
    port_e             lastGrant_q;
    logic              memRead_q;
    logic              memWrite_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;

    logic [1:0]        req_d;
    port_e             winner_d;

    assign req_d = {d_read | d_write, i_read | i_write};

    rr_arb2 u_rr_arb2 (
        .req    (req_d),
        .last   (lastGrant_q),
        .rr_en  (RR_EN),
        .winner (winner_d)
    );

    // Write wins when a port raises read and write together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= PORT_I;
            lastGrant_q <= PORT_I;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_d) begin
                        grant_q     <= winner_d;
                        lastGrant_q <= winner_d;
                        state_q     <= ST_BUSY;
                        if (winner_d == PORT_D) begin
                            memAddr_q  <= d_addr;
                            memWdata_q <= d_wdata;
                            memWrite_q <= d_write;
                            memRead_q  <= d_read & ~d_write;
                        end else begin
                            memAddr_q  <= i_addr;
                            memWdata_q <= i_wdata;
                            memWrite_q <= i_write;
                            memRead_q  <= i_read & ~i_write;
                        end
                    end else begin
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_read  = memRead_q;
    assign mem_write = memWrite_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

    assign i_ready = mem_ready & (state_q == ST_BUSY) & (grant_q == PORT_I);
    assign d_ready = mem_ready & (state_q == ST_BUSY) & (grant_q == PORT_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share all
// inputs and are each checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic [29:0]  addr;
        logic [127:0] wd;
    } req_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, i_write, d_read, d_write;
    logic [29:0]  i_addr, d_addr;
    logic [127:0] i_wdata, d_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [127:0] aIRdata, aDRdata, bIRdata, bDRdata;
    logic         aIReady, aDReady, bIReady, bDReady;
    logic         aMemRead, aMemWrite, bMemRead, bMemWrite;
    logic [29:0]  aMemAddr, bMemAddr;
    logic [127:0] aMemWdata, bMemWdata;

    int checks = 0;
    int errors = 0;
    bit lastA, lastB;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(30), .DATA_W(128), .RR_EN(1'b1)) uA (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(aIRdata), .i_ready(aIReady),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(aDRdata), .d_ready(aDReady),
        .mem_read(aMemRead), .mem_write(aMemWrite), .mem_addr(aMemAddr),
        .mem_wdata(aMemWdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.ADDR_W(30), .DATA_W(128), .RR_EN(1'b0)) uB (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(bIRdata), .i_ready(bIReady),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(bDRdata), .d_ready(bDReady),
        .mem_read(bMemRead), .mem_write(bMemWrite), .mem_addr(bMemAddr),
        .mem_wdata(bMemWdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: 0 = I port, 1 = D port. A lone requester wins; ties go by policy.
    function automatic bit pick(input req_t ir, input req_t dr, input bit last, input bit rr);
        bit iq = ir.rd | ir.wr;
        bit dq = dr.rd | dr.wr;
        if (iq && !dq) return 1'b0;
        if (dq && !iq) return 1'b1;
        return rr ? ~last : 1'b1;
    endfunction

    function automatic req_t mkReq(input logic rd, input logic wr, input logic [29:0] addr,
                                   input logic [127:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd;
        return r;
    endfunction

    function automatic req_t randReq();
        req_t r;
        r.rd   = 1'($urandom_range(0, 1));
        r.wr   = ($urandom_range(0, 3) == 0);
        r.addr = 30'($urandom);
        r.wd   = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    task automatic drivePorts(input req_t ir, input req_t dr);
        i_read = ir.rd; i_write = ir.wr; i_addr = ir.addr; i_wdata = ir.wd;
        d_read = dr.rd; d_write = dr.wr; d_addr = dr.addr; d_wdata = dr.wd;
    endtask

    task automatic clearPorts();
        drivePorts('0, '0);
    endtask

    task automatic checkCmd(input string tag, input req_t eA, input req_t eB);
        check({tag, "/A mem_read"},  128'(aMemRead),  128'(eA.rd & ~eA.wr));
        check({tag, "/A mem_write"}, 128'(aMemWrite), 128'(eA.wr));
        check({tag, "/A mem_addr"},  128'(aMemAddr),  128'(eA.addr));
        check({tag, "/A mem_wdata"}, aMemWdata,       eA.wd);
        check({tag, "/B mem_read"},  128'(bMemRead),  128'(eB.rd & ~eB.wr));
        check({tag, "/B mem_write"}, 128'(bMemWrite), 128'(eB.wr));
        check({tag, "/B mem_addr"},  128'(bMemAddr),  128'(eB.addr));
        check({tag, "/B mem_wdata"}, bMemWdata,       eB.wd);
    endtask

    task automatic checkNoReady(input string tag);
        check({tag, "/A i_ready"}, 128'(aIReady), 128'(0));
        check({tag, "/A d_ready"}, 128'(aDReady), 128'(0));
        check({tag, "/B i_ready"}, 128'(bIReady), 128'(0));
        check({tag, "/B d_ready"}, 128'(bDReady), 128'(0));
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "/A mem_read"},  128'(aMemRead),  128'(0));
        check({tag, "/A mem_write"}, 128'(aMemWrite), 128'(0));
        check({tag, "/B mem_read"},  128'(bMemRead),  128'(0));
        check({tag, "/B mem_write"}, 128'(bMemWrite), 128'(0));
        checkNoReady(tag);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        clearPorts();
        cycle();
        rst_n = 1'b1;
        lastA = 1'b0;
        lastB = 1'b0;
    endtask

    // One full transaction: request in IDLE, hold for `delay` cycles, complete, back to IDLE.
    task automatic applyStimulus(input string tag, input req_t ir, input req_t dr, input int delay,
                                 input logic [127:0] rdata);
        bit gA, gB;
        req_t eA, eB;
        drivePorts(ir, dr);
        if (!(ir.rd | ir.wr | dr.rd | dr.wr)) begin
            cycle();
            checkIdle({tag, "/noreq"});
            return;
        end
        gA = pick(ir, dr, lastA, 1'b1);
        gB = pick(ir, dr, lastB, 1'b0);
        lastA = gA;
        lastB = gB;
        eA = gA ? dr : ir;
        eB = gB ? dr : ir;
        cycle();
        checkCmd({tag, "/cmd"}, eA, eB);
        checkNoReady({tag, "/busy"});
        drivePorts(randReq(), randReq());
        for (int k = 0; k < delay; k++) begin
            cycle();
            checkCmd({tag, "/hold"}, eA, eB);
        end
        mem_rdata = rdata;
        mem_ready = 1'b1;
        #1;
        check({tag, "/A i_ready"}, 128'(aIReady), 128'(gA == 1'b0));
        check({tag, "/A d_ready"}, 128'(aDReady), 128'(gA == 1'b1));
        check({tag, "/B i_ready"}, 128'(bIReady), 128'(gB == 1'b0));
        check({tag, "/B d_ready"}, 128'(bDReady), 128'(gB == 1'b1));
        check({tag, "/A rdata"}, gA ? aDRdata : aIRdata, rdata);
        check({tag, "/B rdata"}, gB ? bDRdata : bIRdata, rdata);
        cycle();
        mem_ready = 1'b0;
        clearPorts();
        checkIdle({tag, "/done"});
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] dead;
        a5   = {16{8'hA5}};
        dead = {4{32'hDEADBEEF}};
        mem_rdata = '0;
        applyReset();
        $display("[TB] reset values");
        checkIdle("reset");
        check("reset/A mem_addr",  128'(aMemAddr), 128'(0));
        check("reset/A mem_wdata", aMemWdata,      128'(0));

        $display("[TB] single I read");
        applyStimulus("iread", mkReq(1, 0, 30'h0000010, '0), '0, 3, a5);

        $display("[TB] D write-back then refill");
        applyStimulus("dwb",  '0, mkReq(0, 1, 30'h1234560, dead), 2, '0);
        applyStimulus("dref", '0, mkReq(1, 0, 30'h0ABCDE0, '0), 1, a5);

        $display("[TB] simultaneous requests from reset");
        applyReset();
        for (int n = 0; n < 3; n++) begin
            applyStimulus("both", mkReq(1, 0, 30'h0000100, '0), mkReq(1, 0, 30'h0000200, '0),
                          n, {4{$urandom}});
        end

        $display("[TB] spurious mem_ready and I read+write");
        mem_ready = 1'b1;
        #1;
        checkNoReady("spurious");
        cycle();
        mem_ready = 1'b0;
        checkIdle("spurious/after");
        applyStimulus("iwr", mkReq(1, 1, 30'h0000300, {4{32'h0BADF00D}}), '0, 0, '0);

        $display("[TB] reset mid-transaction");
        drivePorts(mkReq(1, 0, 30'h0000400, '0), '0);
        cycle();
        check("midrst/A mem_read", 128'(aMemRead), 128'(1));
        rst_n = 1'b0;
        clearPorts();
        cycle();
        rst_n = 1'b1;
        lastA = 1'b0;
        lastB = 1'b0;
        checkIdle("midrst/reset");
        check("midrst/B mem_addr", 128'(bMemAddr), 128'(0));
        mem_ready = 1'b1;
        #1;
        checkNoReady("midrst/ready");
        cycle();
        mem_ready = 1'b0;
        checkIdle("midrst/after");
        applyStimulus("fresh", '0, mkReq(1, 0, 30'h0000500, '0), 1, a5);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 60; n++) begin
            applyStimulus("rand", randReq(), randReq(), int'($urandom_range(0, 3)),
                          {$urandom, $urandom, $urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
